// File: rtl/mem_bus_bridge_if.sv
// Bundle of the hart-side fetch/data ports, the 64-bit memory beat port and the
// sticky error flag. The bridge uses the slave view; the hart and memory side use the master view.
`ifndef IMEM_LINE_DEF
`define IMEM_LINE_DEF 256
`endif
`ifndef DMEM_LINE_DEF
`define DMEM_LINE_DEF 256
`endif

interface mem_bus_bridge_if #(
    parameter int IMEM_LINE = `IMEM_LINE_DEF,
    parameter int DMEM_LINE = `DMEM_LINE_DEF
);
    logic [63:0]          b_addr_i;
    logic                 b_rd_i;
    logic [IMEM_LINE-1:0] b_data_i;
    logic                 b_dv_i;

    logic [63:0]          b_addr;
    logic                 b_rd;
    logic [DMEM_LINE-1:0] b_data_in;
    logic                 b_dv;
    logic [DMEM_LINE-1:0] b_data_out;
    logic                 b_wr;

    logic [63:0]          m_addr;
    logic                 m_rd;
    logic                 m_wr;
    logic [63:0]          m_wdata;
    logic [63:0]          m_rdata;
    logic                 m_ack;

    logic                 err;

    modport slave (
        input  b_addr_i, b_rd_i, b_addr, b_rd, b_data_out, b_wr, m_rdata, m_ack,
        output b_data_i, b_dv_i, b_data_in, b_dv, m_addr, m_rd, m_wr, m_wdata, err
    );

    modport master (
        output b_addr_i, b_rd_i, b_addr, b_rd, b_data_out, b_wr, m_rdata, m_ack,
        input  b_data_i, b_dv_i, b_data_in, b_dv, m_addr, m_rd, m_wr, m_wdata, err
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Bridges line-wide instruction/data requests onto a 64-bit beat memory port,
// with a one-entry write buffer that always drains before any read is granted.
`ifndef IMEM_LINE_DEF
`define IMEM_LINE_DEF 256
`endif
`ifndef DMEM_LINE_DEF
`define DMEM_LINE_DEF 256
`endif

module mem_bus_bridge #(
    parameter int IMEM_LINE = `IMEM_LINE_DEF,
    parameter int DMEM_LINE = `DMEM_LINE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_bridge_if.slave bus
);
    localparam int NI   = IMEM_LINE / 64;
    localparam int ND   = DMEM_LINE / 64;
    localparam int NMAX = (NI > ND) ? NI : ND;
    localparam int LMAX = NMAX * 64;
    localparam int CW   = $clog2(NMAX) + 1;
    localparam logic [63:0] IMASK = ~64'(IMEM_LINE / 8 - 1);
    localparam logic [63:0] DMASK = ~64'(DMEM_LINE / 8 - 1);
    localparam logic [CW-1:0] I_LAST = CW'(NI - 1);
    localparam logic [CW-1:0] D_LAST = CW'(ND - 1);

    typedef enum logic [2:0] {IDLE, IRD, DRD, DWR, IRSP, DRSP} state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        beat;
    logic [63:0]          beat_off;
    logic [63:0]          rd_base;
    logic [LMAX-1:0]      rd_line;
    logic                 wb_full;
    logic [63:0]          wb_base;
    logic [DMEM_LINE-1:0] wb_line;
    logic                 last_data;
    logic                 err_q;
    logic                 wr_done;
    logic                 wb_free;

    assign beat_off = 64'({beat, 3'b000});
    assign wr_done  = (state == DWR) && bus.m_ack && (beat == D_LAST);
    // A write arriving in the cycle the buffer drains takes the freed slot.
    assign wb_free  = !wb_full || wr_done;
    assign bus.err  = err_q;

    always_comb begin
        state_next    = state;
        bus.m_rd      = 1'b0;
        bus.m_wr      = 1'b0;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.b_dv_i    = 1'b0;
        bus.b_data_i  = '0;
        bus.b_dv      = 1'b0;
        bus.b_data_in = '0;
        case (state)
            IDLE: begin
                // A write captured this same cycle still counts as pending ahead of reads.
                if (wb_full || bus.b_wr)
                    state_next = DWR;
                else if (bus.b_rd && bus.b_rd_i)
                    state_next = last_data ? IRD : DRD;
                else if (bus.b_rd)
                    state_next = DRD;
                else if (bus.b_rd_i)
                    state_next = IRD;
            end
            IRD: begin
                bus.m_rd   = 1'b1;
                bus.m_addr = rd_base + beat_off;
                if (bus.m_ack && beat == I_LAST)
                    state_next = IRSP;
            end
            DRD: begin
                bus.m_rd   = 1'b1;
                bus.m_addr = rd_base + beat_off;
                if (bus.m_ack && beat == D_LAST)
                    state_next = DRSP;
            end
            DWR: begin
                bus.m_wr    = 1'b1;
                bus.m_addr  = wb_base + beat_off;
                bus.m_wdata = wb_line[64*beat +: 64];
                if (wr_done)
                    state_next = IDLE;
            end
            IRSP: begin
                bus.b_dv_i   = 1'b1;
                bus.b_data_i = rd_line[IMEM_LINE-1:0];
                state_next   = IDLE;
            end
            DRSP: begin
                bus.b_dv      = 1'b1;
                bus.b_data_in = rd_line[DMEM_LINE-1:0];
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            wb_full   <= 1'b0;
            last_data <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                beat <= '0;
                if (state_next == IRD) begin
                    rd_base   <= bus.b_addr_i & IMASK;
                    last_data <= 1'b0;
                end else if (state_next == DRD) begin
                    rd_base   <= bus.b_addr & DMASK;
                    last_data <= 1'b1;
                end
            end else if ((state == IRD || state == DRD || state == DWR) && bus.m_ack) begin
                if (state != DWR)
                    rd_line[64*beat +: 64] <= bus.m_rdata;
                beat <= (state_next != state) ? '0 : beat + 1'b1;
            end

            if (bus.b_wr) begin
                if (wb_free) begin
                    wb_full <= 1'b1;
                    wb_base <= bus.b_addr & DMASK;
                    wb_line <= bus.b_data_out;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (wr_done) begin
                wb_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: 256-bit lines (4 beats) against a small
// behavioural memory with optional per-beat ack stalls.
module tb_mem_bus_bridge;
    localparam int IL = 256;
    localparam int DL = 256;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   stall = 0;
    int   wait_cnt = 0;
    logic [63:0]  mem [logic [63:0]];
    logic [255:0] aa_line;
    logic [255:0] d1;
    logic [255:0] d2;
    logic [255:0] d3;

    mem_bus_bridge_if #(.IMEM_LINE(IL), .DMEM_LINE(DL)) bus ();

    mem_bus_bridge #(.IMEM_LINE(IL), .DMEM_LINE(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [63:0] a);
        return {~a[31:0], a[31:0] ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [255:0] exp_line(input logic [63:0] base);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 4; k++)
            l[64*k +: 64] = pat(base + 64'(8 * k));
        return l;
    endfunction

    // Memory side: decides ack, records write beats and presents read data mid-cycle.
    always @(negedge clk) begin
        if (bus.m_rd || bus.m_wr) begin
            if (stall == 0 || wait_cnt == stall) begin
                bus.m_ack = 1'b1;
                wait_cnt  = 0;
            end else begin
                bus.m_ack = 1'b0;
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            bus.m_ack = 1'b0;
            wait_cnt  = 0;
        end
        if (bus.m_wr && bus.m_ack)
            mem[bus.m_addr] = bus.m_wdata;
        bus.m_rdata = mem.exists(bus.m_addr) ? mem[bus.m_addr] : pat(bus.m_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [63:0] addr,
                                 input logic rd_i, input logic [63:0] addr_i,
                                 input logic wr, input logic [255:0] wdata);
        bus.b_rd       = rd;
        bus.b_addr     = addr;
        bus.b_rd_i     = rd_i;
        bus.b_addr_i   = addr_i;
        bus.b_wr       = wr;
        bus.b_data_out = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            d1[64*k +: 64] = 64'h8080_0000_0000_0000 | 64'(k);
            d2[64*k +: 64] = 64'hC0C0_0000_0000_0000 | 64'(k);
            d3[64*k +: 64] = 64'h1401_0000_0000_0000 | 64'(k);
        end
        aa_line = {32{8'hAA}};

        // Reset state: everything quiet.
        doReset();
        checkOutput("reset_ctrl", {bus.m_rd, bus.m_wr, bus.b_dv, bus.b_dv_i, bus.err}, 5'b0);
        checkOutput("reset_maddr", bus.m_addr, 64'h0);

        // Single data read at 0x104, address changes after grant must be ignored.
        applyStimulus(1'b1, 64'h104, 1'b0, 64'h0, 1'b0, '0);
        step();
        applyStimulus(1'b1, 64'h999, 1'b0, 64'h0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drd_mrd_%0d", k), {bus.m_rd, bus.m_wr, bus.b_dv}, 3'b100);
            checkOutput($sformatf("drd_addr_%0d", k), bus.m_addr, 64'h100 + 64'(8 * k));
            step();
        end
        checkOutput("drd_dv", {bus.b_dv, bus.m_rd}, 2'b10);
        checkOutput("drd_line", bus.b_data_in, exp_line(64'h100));
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        step();
        checkOutput("drd_after", {bus.b_dv, bus.m_rd}, 2'b00);
        checkOutput("drd_after_data", bus.b_data_in, '0);

        // Both ports held after reset: data first, then alternating.
        doReset();
        applyStimulus(1'b1, 64'h200, 1'b1, 64'h300, 1'b0, '0);
        for (int t = 0; t < 4; t++) begin
            checkOutput($sformatf("arb_idle_%0d", t), bus.m_rd, 1'b0);
            step();
            checkOutput($sformatf("arb_addr_%0d", t), bus.m_addr, (t % 2 == 0) ? 64'h200 : 64'h300);
            step(); step(); step(); step();
            checkOutput($sformatf("arb_dv_%0d", t), {bus.b_dv, bus.b_dv_i},
                        (t % 2 == 0) ? 2'b10 : 2'b01);
            if (t % 2 == 0)
                checkOutput($sformatf("arb_dline_%0d", t), bus.b_data_in, exp_line(64'h200));
            else
                checkOutput($sformatf("arb_iline_%0d", t), bus.b_data_i, exp_line(64'h300));
            step();
        end

        // Write and read of the same line in one cycle: write drains first.
        doReset();
        applyStimulus(1'b1, 64'h40, 1'b0, 64'h0, 1'b1, aa_line);
        step();
        applyStimulus(1'b1, 64'h40, 1'b0, 64'h0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("raw_wr_%0d", k), {bus.m_wr, bus.m_rd}, 2'b10);
            checkOutput($sformatf("raw_waddr_%0d", k), bus.m_addr, 64'h40 + 64'(8 * k));
            checkOutput($sformatf("raw_wdata_%0d", k), bus.m_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
            step();
        end
        checkOutput("raw_idle", {bus.m_wr, bus.m_rd}, 2'b00);
        step();
        checkOutput("raw_rd_addr", {bus.m_rd, bus.m_addr}, {1'b1, 64'h40});
        step(); step(); step(); step();
        checkOutput("raw_dv", bus.b_dv, 1'b1);
        checkOutput("raw_line", bus.b_data_in, aa_line);
        checkOutput("raw_err", bus.err, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        step();

        // Write accepted as the buffer drains, the next one is dropped and err sticks.
        applyStimulus(1'b0, 64'h80, 1'b0, 64'h0, 1'b1, d1);
        step();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("wb1_addr_%0d", k), {bus.m_wr, bus.m_addr}, {1'b1, 64'h80 + 64'(8 * k)});
            checkOutput($sformatf("wb1_data_%0d", k), bus.m_wdata, d1[64*k +: 64]);
            if (k == 3)
                applyStimulus(1'b0, 64'hC0, 1'b0, 64'h0, 1'b1, d2);
            step();
        end
        applyStimulus(1'b0, 64'h140, 1'b0, 64'h0, 1'b1, d3);
        checkOutput("wb_err_before", bus.err, 1'b0);
        step();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        checkOutput("wb_err_set", bus.err, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("wb2_addr_%0d", k), {bus.m_wr, bus.m_addr}, {1'b1, 64'hC0 + 64'(8 * k)});
            checkOutput($sformatf("wb2_data_%0d", k), bus.m_wdata, d2[64*k +: 64]);
            step();
        end
        checkOutput("wb_drop_idle", {bus.m_wr, bus.m_rd}, 2'b00);
        step();
        checkOutput("wb_drop_idle2", {bus.m_wr, bus.m_rd, bus.err}, 3'b001);

        // Reset clears the sticky error.
        rst = 1'b1;
        step();
        checkOutput("rst_err", bus.err, 1'b0);

        // Fetch with three stall cycles per beat.
        doReset();
        stall = 3;
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h500, 1'b0, '0);
        step();
        for (int c = 1; c <= 16; c++) begin
            checkOutput($sformatf("stall_rd_%0d", c), {bus.m_rd, bus.b_dv_i}, 2'b10);
            checkOutput($sformatf("stall_addr_%0d", c), bus.m_addr, 64'h500 + 64'(8 * ((c - 1) / 4)));
            step();
        end
        checkOutput("stall_dv", bus.b_dv_i, 1'b1);
        checkOutput("stall_line", bus.b_data_i, exp_line(64'h500));
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        stall = 0;
        step();

        // Reset during beat 2 of a fetch aborts it.
        doReset();
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h600, 1'b0, '0);
        step();
        step();
        step();
        checkOutput("abort_beat2", {bus.m_rd, bus.m_addr}, {1'b1, 64'h610});
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, '0);
        checkOutput("abort_stop", {bus.m_rd, bus.m_wr, bus.b_dv_i}, 3'b000);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput($sformatf("abort_quiet_%0d", c), {bus.m_rd, bus.m_wr, bus.b_dv_i}, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
